pid_ahb_master: RTL and testbench
=================================

Name: pid_ahb_master

Overview:
- AHB-Lite master that drives the PID accelerator's AHB slave register map from the other end of the bus.
- On a configuration request it programs InitN and six coefficients, then releases InitN.
- It then streams din0/din1 sample pairs, accepted over a valid/ready handshake, as bus writes.
- It sits between the sensor/sample front end and the AHB interconnect in the PID workload.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the PID slave; register offsets are added to it.
- DW, 25, coefficient/sample width; zero-extended to 32 bits on HWDATA.
- TIMEOUT_CYCLES, 256, wait-state limit (used only with the optional feature).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle request to run the configuration sequence
- coeff0..coeff5  in  DW each  coefficient values, captured on accepted cfg_start
- cfg_done  out  1  one-cycle pulse when configuration has completed
- sample_valid  in  1  sample pair offered
- sample_ready  out  1  master can accept a sample pair this cycle
- sample_din0, sample_din1  in  DW each  sample pair
- busy  out  1  high while any transfer is outstanding or a sequence is running
- err  out  1  sticky bus-error flag
- HADDR  out  32;  HTRANS  out  2;  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3;  HPROT  out  4;  HMASTLOCK  out  1;  HWDATA  out  32
- HRDATA  in  32  unused
- HREADY  in  1  transfer complete / wait state
- HRESP  in  2  2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Reset values (asynchronous, while HRESETn=0):
  - HTRANS=IDLE(2'b00), HADDR=0, HWDATA=0, HWRITE=0.
  - cfg_done=0, sample_ready=0, busy=0, err=0, state=IDLE.
- Fixed outputs: HSIZE=3'b010, HBURST=SINGLE(3'b000), HPROT=4'b0011, HMASTLOCK=0.
- Register offsets: INITN 0x00, COEFF0-5 0x04-0x18, DIN0 0x1C, DIN1 0x20.
- Transfers: all writes, every beat HTRANS=NONSEQ.
  - The address of beat n+1 overlaps the data phase of beat n.
  - HWDATA for a beat is registered when its address phase completes (HREADY=1).
  - Address, control and HWDATA are held stable while HREADY=0.
- States:
  - IDLE:
    - cfg_start captures coeff0-5 into shadow registers, sets busy=1 and moves to CFG.
    - sample_ready=0 in this state.
  - CFG: 8 writes in order: INITN=0, COEFF0..COEFF5, INITN=1.
    - cfg_done pulses the cycle after the final data phase completes.
    - The state then moves to STREAM.
    - With zero wait states: cfg_start at cycle 0, address phases at cycles 1-8, last data phase at cycle 9, cfg_done at cycle 10.
  - STREAM:
    - sample_ready=1 only when no transfer is outstanding.
    - On valid&&ready both samples are latched.
    - DIN0 and DIN1 writes issue on the next two cycles.
    - sample_ready reasserts the cycle after the DIN1 data phase completes (zero wait: accept at t, ready again at t+4).
    - cfg_start while ready takes priority over a simultaneous sample_valid; the sample is not accepted and the state moves to CFG.
    - cfg_start while a transfer is outstanding is ignored.
  - ERR:
    - Entered when HRESP=ERROR during the first response cycle (HREADY=0).
    - HTRANS is driven IDLE in the next cycle, cancelling any pipelined beat.
    - err is set sticky, busy is cleared and sample_ready=0.
    - cfg_start clears err and restarts CFG.
- cfg_done and err never assert in the same cycle.
- Reset during a transfer aborts it immediately; no write completes afterwards.

Optional Feature:
- Macro: PID_AHB_MASTER_TIMEOUT_EN.
- When defined:
  - A counter runs during consecutive HREADY=0 cycles of a data phase.
  - Reaching TIMEOUT_CYCLES forces HTRANS=IDLE, sets err and enters ERR.
  - The counter clears whenever HREADY=1.
- When undefined: no counter; the master waits indefinitely.

Decomposition:
- Shared package pid_ahb_pkg holds:
  - register offset constants;
  - HTRANS/HRESP/HSIZE/HBURST encodings;
  - the FSM state enum;
  - DW default.
  The existing slave should import the same package.
- One natural sub-module: pid_ahb_beat, the single-write pipeline engine that:
  - takes addr/data with req/ack;
  - handles HREADY hold and two-cycle ERROR;
  - reports beat completion and errors to the sequencing FSM.

Test Plan:
- Config, zero wait:
  - Stimulus: cfg_start with coeff0=25'h0000123 … coeff5=25'h1FFFFFF.
  - Response: HADDR sequence BASE+00,04,…,18,00; HWDATA 0, coefficients, 1; cfg_done at cycle 10.
- Wait states:
  - Stimulus: slave holds HREADY=0 for 3 cycles on COEFF2 data phase.
  - Response: HADDR/HWDATA stable during the stall; cfg_done delayed by exactly 3 cycles.
- Streaming:
  - Stimulus: two back-to-back pairs (din0=25'h10, din1=25'h20; 25'h30, 25'h40).
  - Response: writes to 0x1C/0x20 in order; sample_ready low between the pairs; second pair accepted 4 cycles after the first.
- Error:
  - Stimulus: HRESP=ERROR on COEFF4.
  - Response: HTRANS=IDLE next cycle (COEFF5 beat cancelled), err=1, no cfg_done; a subsequent cfg_start clears err and reruns all 8 writes.
- Priority:
  - Stimulus: cfg_start and sample_valid together in STREAM.
  - Response: sample not accepted; CFG sequence runs.
- Reset mid-transfer:
  - Stimulus: HRESETn low during a DIN0 data phase.
  - Response: all outputs at reset values immediately.
- With PID_AHB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - Stimulus: HREADY held low.
  - Response: err after 8 stalled cycles.

Source files
------------

// File: rtl/pid_ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_ahb_pkg
// Description : Shared definitions for the PID accelerator AHB-Lite link:
//               register offsets, AHB encodings, master FSM states and the
//               default coefficient/sample width.
// Revision    : 1.0  initial release
// ============================================================================
package pid_ahb_pkg;

    // Default coefficient / sample width
    localparam int c_PID_DW = 25;

    // PID slave register offsets
    localparam logic [31:0] c_OFF_INITN  = 32'h00;
    localparam logic [31:0] c_OFF_COEFF0 = 32'h04;
    localparam logic [31:0] c_OFF_COEFF1 = 32'h08;
    localparam logic [31:0] c_OFF_COEFF2 = 32'h0C;
    localparam logic [31:0] c_OFF_COEFF3 = 32'h10;
    localparam logic [31:0] c_OFF_COEFF4 = 32'h14;
    localparam logic [31:0] c_OFF_COEFF5 = 32'h18;
    localparam logic [31:0] c_OFF_DIN0   = 32'h1C;
    localparam logic [31:0] c_OFF_DIN1   = 32'h20;

    // AHB-Lite encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
    localparam logic [1:0] c_HRESP_ERROR   = 2'b01;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
    localparam logic [3:0] c_HPROT_DATA    = 4'b0011;

    // Number of writes in the configuration sequence
    localparam logic [3:0] c_CFG_BEATS = 4'd8;

    // Master sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_STREAM = 2'd2,
        ST_ERR    = 2'd3
    } pid_state_t;

    // Register offset of configuration beat idx (0 and 7 both hit INITN)
    function automatic logic [31:0] cfg_offset(input logic [3:0] idx);
        logic [31:0] off;
        case (idx)
            4'd1:    off = c_OFF_COEFF0;
            4'd2:    off = c_OFF_COEFF1;
            4'd3:    off = c_OFF_COEFF2;
            4'd4:    off = c_OFF_COEFF3;
            4'd5:    off = c_OFF_COEFF4;
            4'd6:    off = c_OFF_COEFF5;
            default: off = c_OFF_INITN;
        endcase
        return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_ahb_beat.sv
`default_nettype none
// ============================================================================
// Module      : pid_ahb_beat
// Description : Single-write AHB-Lite pipeline engine. Accepts one address/
//               data pair per req/ack, overlaps the next address phase with
//               the current data phase, holds everything across HREADY=0 and
//               cancels the pipelined beat on a two-cycle ERROR response.
//               Optional macro PID_AHB_MASTER_TIMEOUT_EN adds a wait-state
//               limit of TIMEOUT_CYCLES stalled data-phase cycles.
// Revision    : 1.0  initial release
// ============================================================================
module pid_ahb_beat
    import pid_ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_ack,
    output logic        o_done,
    output logic        o_err,
    output logic        o_aphase,
    output logic [31:0] o_haddr,
    output logic [1:0]  o_htrans,
    output logic        o_hwrite,
    output logic [31:0] o_hwdata,
    input  logic        i_hready,
    input  logic [1:0]  i_hresp
);

    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic [31:0] r_adata;     // data belonging to the beat in address phase
    logic [31:0] r_hwdata;
    logic        r_hwrite;
    logic        r_dphase;

    logic w_aphase;
    logic w_resp_err;
    logic w_timeout;
    logic w_err;

    assign w_aphase   = (r_htrans == c_HTRANS_NONSEQ);
    // First cycle of a two-cycle ERROR response
    assign w_resp_err = r_dphase && !i_hready && (i_hresp == c_HRESP_ERROR);
    assign w_err      = w_resp_err || w_timeout;

    // A new beat may load when no address phase is pending or it completes now
    assign o_ack    = i_req && !w_err && (!w_aphase || i_hready);
    assign o_done   = r_dphase && i_hready;
    assign o_err    = w_err;
    assign o_aphase = w_aphase;

`ifdef PID_AHB_MASTER_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    assign w_timeout = r_dphase && !i_hready &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled data-phase cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!r_dphase || i_hready || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end
`else
    // Without the limit the master waits on HREADY indefinitely
    localparam int c_timeout_unused = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Address/data pipeline with HREADY hold and error cancellation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_htrans <= c_HTRANS_IDLE;
            r_haddr  <= '0;
            r_adata  <= '0;
            r_hwdata <= '0;
            r_hwrite <= 1'b0;
            r_dphase <= 1'b0;
        end else if (w_err) begin
            // Drop the pipelined beat; HWDATA stays for the second error cycle
            r_htrans <= c_HTRANS_IDLE;
            r_dphase <= 1'b0;
        end else begin
            if (w_aphase && i_hready) begin
                r_dphase <= 1'b1;
                r_hwdata <= r_adata;
            end else if (r_dphase && i_hready) begin
                r_dphase <= 1'b0;
            end
            if (o_ack) begin
                r_htrans <= c_HTRANS_NONSEQ;
                r_haddr  <= i_addr;
                r_adata  <= i_data;
                r_hwrite <= 1'b1;
            end else if (w_aphase && i_hready) begin
                r_htrans <= c_HTRANS_IDLE;
            end
        end
    end

    assign o_htrans = r_htrans;
    assign o_haddr  = r_haddr;
    assign o_hwdata = r_hwdata;
    assign o_hwrite = r_hwrite;

endmodule
`default_nettype wire

// File: rtl/pid_ahb_master.sv
`default_nettype none
// ============================================================================
// Module      : pid_ahb_master
// Description : AHB-Lite master that programs the PID slave (INITN low, six
//               coefficients, INITN high) and then streams din0/din1 sample
//               pairs as bus writes. Optional macro PID_AHB_MASTER_TIMEOUT_EN
//               enables the wait-state timeout in the beat engine.
// Revision    : 1.0  initial release
// ============================================================================
module pid_ahb_master
    import pid_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          DW             = c_PID_DW,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cfg_start,
    input  logic [DW-1:0] coeff0,
    input  logic [DW-1:0] coeff1,
    input  logic [DW-1:0] coeff2,
    input  logic [DW-1:0] coeff3,
    input  logic [DW-1:0] coeff4,
    input  logic [DW-1:0] coeff5,
    output logic          cfg_done,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [DW-1:0] sample_din0,
    input  logic [DW-1:0] sample_din1,
    output logic          busy,
    output logic          err,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic [1:0]    HRESP
);

    pid_state_t  r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;           // configuration beats issued
    logic        r_ready, w_ready_nxt;
    logic        r_err, w_err_nxt;
    logic        r_done, w_done_nxt;
    logic        r_din1_pend, w_din1_pend_nxt;
    logic [DW-1:0] r_coeff [6];
    logic [DW-1:0] r_din1;

    logic        w_go;
    logic        w_req;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_data;
    logic        w_ack;
    logic        w_bdone;
    logic        w_berr;
    logic        w_baphase;
    logic        w_accept;
    logic        w_hrdata_unused;

    assign w_hrdata_unused = ^HRDATA;

    // Bus request for the current state; independent of the engine's ack
    always_comb begin
        w_go       = cfg_start && ((r_state == ST_IDLE) || (r_state == ST_ERR) ||
                                   ((r_state == ST_STREAM) && r_ready));
        w_req      = 1'b0;
        w_req_addr = BASE_ADDR;
        w_req_data = 32'd0;
        if (w_go) begin
            w_req      = 1'b1;
            w_req_addr = BASE_ADDR + c_OFF_INITN;
            w_req_data = 32'd0;
        end else if (r_state == ST_CFG && r_idx < c_CFG_BEATS) begin
            w_req      = 1'b1;
            w_req_addr = BASE_ADDR + cfg_offset(r_idx);
            case (r_idx)
                4'd1:    w_req_data = 32'(r_coeff[0]);
                4'd2:    w_req_data = 32'(r_coeff[1]);
                4'd3:    w_req_data = 32'(r_coeff[2]);
                4'd4:    w_req_data = 32'(r_coeff[3]);
                4'd5:    w_req_data = 32'(r_coeff[4]);
                4'd6:    w_req_data = 32'(r_coeff[5]);
                4'd7:    w_req_data = 32'd1;
                default: w_req_data = 32'd0;
            endcase
        end else if (r_state == ST_STREAM && r_ready && sample_valid) begin
            w_req      = 1'b1;
            w_req_addr = BASE_ADDR + c_OFF_DIN0;
            w_req_data = 32'(sample_din0);
        end else if (r_state == ST_STREAM && r_din1_pend) begin
            w_req      = 1'b1;
            w_req_addr = BASE_ADDR + c_OFF_DIN1;
            w_req_data = 32'(r_din1);
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_ready_nxt     = r_ready;
        w_err_nxt       = r_err;
        w_done_nxt      = 1'b0;
        w_din1_pend_nxt = r_din1_pend;
        w_accept        = 1'b0;
        if (w_go) begin
            w_state_nxt     = ST_CFG;
            w_idx_nxt       = w_ack ? 4'd1 : 4'd0;
            w_ready_nxt     = 1'b0;
            w_err_nxt       = 1'b0;
            w_din1_pend_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_CFG: begin
                    if (r_idx < c_CFG_BEATS) begin
                        if (w_ack) begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end else if (w_bdone && !w_baphase) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_STREAM;
                        w_ready_nxt = 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (r_ready) begin
                        if (sample_valid && w_ack) begin
                            w_accept        = 1'b1;
                            w_ready_nxt     = 1'b0;
                            w_din1_pend_nxt = 1'b1;
                        end
                    end else if (r_din1_pend) begin
                        if (w_ack) begin
                            w_din1_pend_nxt = 1'b0;
                        end
                    end else if (w_bdone && !w_baphase) begin
                        w_ready_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_berr) begin
            w_state_nxt     = ST_ERR;
            w_err_nxt       = 1'b1;
            w_ready_nxt     = 1'b0;
            w_din1_pend_nxt = 1'b0;
            w_done_nxt      = 1'b0;
        end
    end

    // State and status registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_idx       <= 4'd0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_din1_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ready     <= w_ready_nxt;
            r_err       <= w_err_nxt;
            r_done      <= w_done_nxt;
            r_din1_pend <= w_din1_pend_nxt;
        end
    end

    // Coefficient shadows on a started configuration, din1 on an accepted pair
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 6; i++) begin
                r_coeff[i] <= '0;
            end
            r_din1 <= '0;
        end else begin
            if (w_go) begin
                r_coeff[0] <= coeff0;
                r_coeff[1] <= coeff1;
                r_coeff[2] <= coeff2;
                r_coeff[3] <= coeff3;
                r_coeff[4] <= coeff4;
                r_coeff[5] <= coeff5;
            end
            if (w_accept) begin
                r_din1 <= sample_din1;
            end
        end
    end

    pid_ahb_beat #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_beat (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .i_req    (w_req),
        .i_addr   (w_req_addr),
        .i_data   (w_req_data),
        .o_ack    (w_ack),
        .o_done   (w_bdone),
        .o_err    (w_berr),
        .o_aphase (w_baphase),
        .o_haddr  (HADDR),
        .o_htrans (HTRANS),
        .o_hwrite (HWRITE),
        .o_hwdata (HWDATA),
        .i_hready (HREADY),
        .i_hresp  (HRESP)
    );

    assign cfg_done     = r_done;
    assign sample_ready = r_ready;
    assign err          = r_err;
    assign busy         = (r_state == ST_CFG) || ((r_state == ST_STREAM) && !r_ready);

    assign HSIZE     = c_HSIZE_WORD;
    assign HBURST    = c_HBURST_SINGLE;
    assign HPROT     = c_HPROT_DATA;
    assign HMASTLOCK = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pid_ahb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_ahb_master
// Description : Directed self-checking bench for pid_ahb_master: reset values,
//               zero-wait and stalled configuration, streaming, error abort,
//               priority of cfg_start, reset mid-transfer and (with
//               PID_AHB_MASTER_TIMEOUT_EN) the wait-state timeout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pid_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cfg_start;
    logic [24:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5;
    logic        cfg_done;
    logic        sample_valid;
    logic        sample_ready;
    logic [24:0] sample_din0, sample_din1;
    logic        busy, err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr [8];
    logic [31:0] exp_data [8];

    pid_ahb_master #(
        .BASE_ADDR      (32'h0000_0000),
        .DW             (25),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .cfg_start    (cfg_start),
        .coeff0       (coeff0),
        .coeff1       (coeff1),
        .coeff2       (coeff2),
        .coeff3       (coeff3),
        .coeff4       (coeff4),
        .coeff5       (coeff5),
        .cfg_done     (cfg_done),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_din0  (sample_din0),
        .sample_din1  (sample_din1),
        .busy         (busy),
        .err          (err),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HPROT        (HPROT),
        .HMASTLOCK    (HMASTLOCK),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // cfg_start is driven in the current cycle (cycle 0); models an AHB slave
    // that stalls the data phase of beat stall_beat for stall_len cycles
    task automatic run_cfg(input string tag, input int stall_beat, input int stall_len,
                           input int exp_done_cyc);
        int c, aidx, dph, stall_cnt, done_c;
        bit dvalid, hr;
        aidx = 0; dph = 0; stall_cnt = 0; done_c = -1; dvalid = 0;
        tick();
        cfg_start    = 1'b0;
        sample_valid = 1'b0;
        c = 1;
        check_val({tag, " busy"}, 32'(busy), 32'd1);
        check_val({tag, " err clear"}, 32'(err), 32'd0);
        while (c <= 40 && done_c < 0) begin
            hr = 1'b1;
            if (dvalid) begin
                check_val({tag, " hwdata"}, HWDATA, (dph < 8) ? exp_data[dph] : 32'hDEAD_BEEF);
                if (dph == stall_beat && stall_cnt < stall_len) begin
                    hr = 1'b0;
                    stall_cnt++;
                end
            end
            HREADY = hr;
            if (HTRANS == 2'b10) begin
                if (aidx < 8) check_val({tag, " haddr"}, HADDR, exp_addr[aidx]);
                else          check_val({tag, " extra beat"}, 32'(aidx), 32'd7);
            end
            if (dvalid && hr) dvalid = 1'b0;
            if (HTRANS == 2'b10 && hr) begin
                dvalid = 1'b1;
                dph    = aidx;
                aidx++;
            end
            if (cfg_done) begin
                done_c = c;
            end else begin
                tick();
                c++;
            end
        end
        HREADY = 1'b1;
        check_val({tag, " beats"}, 32'(aidx), 32'd8);
        check_val({tag, " done cycle"}, 32'(done_c), 32'(exp_done_cyc));
        check_val({tag, " ready at done"}, 32'(sample_ready), 32'd1);
        check_val({tag, " no err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; cfg_start = 1'b0; sample_valid = 1'b0;
        sample_din0 = '0; sample_din1 = '0;
        HRDATA = 32'd0; HREADY = 1'b1; HRESP = 2'b00;
        coeff0 = 25'h0000123; coeff1 = 25'h0ABCDEF; coeff2 = 25'h1000000;
        coeff3 = 25'h0055AA5; coeff4 = 25'h0000001; coeff5 = 25'h1FFFFFF;
        exp_addr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h00};
        exp_data = '{32'h0, 32'h0000123, 32'h0ABCDEF, 32'h1000000,
                     32'h0055AA5, 32'h0000001, 32'h1FFFFFF, 32'h1};

        // Reset values and fixed outputs
        repeat (2) @(posedge HCLK);
        #1;
        check_val("rst htrans", 32'(HTRANS), 32'd0);
        check_val("rst haddr", HADDR, 32'd0);
        check_val("rst hwdata", HWDATA, 32'd0);
        check_val("rst hwrite", 32'(HWRITE), 32'd0);
        check_val("rst status", {28'd0, cfg_done, sample_ready, busy, err}, 32'd0);
        check_val("fixed ctrl", {20'd0, HSIZE, HBURST, HPROT, HMASTLOCK, 1'b0}, {20'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
        HRESETn = 1'b1;
        tick();
        check_val("idle ready", 32'(sample_ready), 32'd0);

        // Configuration with zero wait states
        cfg_start = 1'b1;
        run_cfg("cfg0", -1, 0, 10);

        // Two back-to-back sample pairs, first accepted in this cycle (t)
        sample_valid = 1'b1; sample_din0 = 25'h10; sample_din1 = 25'h20;
        tick();  // t+1
        check_val("s1 din0 addr", HADDR, 32'h1C);
        check_val("s1 htrans", 32'(HTRANS), 32'h2);
        check_val("s1 ready low", 32'(sample_ready), 32'd0);
        check_val("done pulse", 32'(cfg_done), 32'd0);
        check_val("s1 busy", 32'(busy), 32'd1);
        sample_din0 = 25'h30; sample_din1 = 25'h40;
        tick();  // t+2
        check_val("s1 din1 addr", HADDR, 32'h20);
        check_val("s1 din0 data", HWDATA, 32'h10);
        check_val("s1 ready t2", 32'(sample_ready), 32'd0);
        tick();  // t+3
        check_val("s1 din1 data", HWDATA, 32'h20);
        check_val("s1 ready t3", 32'(sample_ready), 32'd0);
        tick();  // t+4: second pair accepted at the end of this cycle
        check_val("s1 ready t4", 32'(sample_ready), 32'd1);
        tick();  // t+5
        sample_valid = 1'b0;
        check_val("s2 din0 addr", HADDR, 32'h1C);
        check_val("s2 ready low", 32'(sample_ready), 32'd0);
        tick();
        check_val("s2 din1 addr", HADDR, 32'h20);
        check_val("s2 din0 data", HWDATA, 32'h30);
        tick();
        check_val("s2 din1 data", HWDATA, 32'h40);
        tick();  // t+8
        check_val("s2 ready again", 32'(sample_ready), 32'd1);
        check_val("s2 bus idle", 32'(HTRANS), 32'd0);

        // cfg_start and sample_valid together: configuration wins
        cfg_start = 1'b1; sample_valid = 1'b1;
        sample_din0 = 25'h55; sample_din1 = 25'h66;
        run_cfg("prio", -1, 0, 10);

        // Three wait states on the COEFF2 data phase
        cfg_start = 1'b1;
        run_cfg("wait", 3, 3, 13);

        // ERROR response on COEFF4 data phase
        cfg_start = 1'b1;
        tick();  // cycle 1
        cfg_start = 1'b0;
        repeat (6) tick();  // cycle 7
        check_val("err c5 addr", HADDR, 32'h18);
        check_val("err c4 data", HWDATA, 32'h0000001);
        HREADY = 1'b0; HRESP = 2'b01;
        tick();  // cycle 8
        check_val("err cancel", 32'(HTRANS), 32'd0);
        check_val("err set", 32'(err), 32'd1);
        check_val("err busy", 32'(busy), 32'd0);
        check_val("err ready", 32'(sample_ready), 32'd0);
        check_val("err no done", 32'(cfg_done), 32'd0);
        HREADY = 1'b1;
        tick();  // cycle 9
        HRESP = 2'b00;
        check_val("err idle2", 32'(HTRANS), 32'd0);
        check_val("err no done2", 32'(cfg_done), 32'd0);
        repeat (3) tick();
        check_val("err sticky", 32'(err), 32'd1);
        check_val("err idle3", 32'(HTRANS), 32'd0);
        cfg_start = 1'b1;
        run_cfg("rerun", -1, 0, 10);

        // Reset during a DIN0 data phase
        sample_valid = 1'b1; sample_din0 = 25'h77; sample_din1 = 25'h88;
        tick();
        sample_valid = 1'b0;
        tick();  // DIN0 data phase
        check_val("rst mid data", HWDATA, 32'h77);
        HREADY = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        check_val("rstm htrans", 32'(HTRANS), 32'd0);
        check_val("rstm haddr", HADDR, 32'd0);
        check_val("rstm hwdata", HWDATA, 32'd0);
        check_val("rstm hwrite", 32'(HWRITE), 32'd0);
        check_val("rstm status", {28'd0, cfg_done, sample_ready, busy, err}, 32'd0);
        HREADY = 1'b1;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("post rst idle", {30'd0, HTRANS}, 32'd0);
        end

`ifdef PID_AHB_MASTER_TIMEOUT_EN
        // Slave never completes the INITN data phase
        cfg_start = 1'b1;
        tick();  // cycle 1
        cfg_start = 1'b0;
        tick();  // cycle 2: first stalled data-phase cycle
        HREADY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_val("to not yet", 32'(err), 32'd0);
        end
        tick();
        check_val("to err", 32'(err), 32'd1);
        check_val("to idle", 32'(HTRANS), 32'd0);
        HREADY = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
